// File: rtl/pc_sequencer.sv
// Fetch-PC sequencer with delay-slot branch/jump redirect, exception entry/return
// and a circular return-address stack for call/return prediction.
module pc_sequencer #(
  parameter int             AW        = 32,
  parameter logic [AW-1:0]  RESET_PC  = 'h0000_3000,
  parameter logic [AW-1:0]  EXC_PC    = 'h0000_4180,
  parameter int             RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic [AW-1:0] id_pc,
  input  logic [2:0]    br_type,
  input  logic [AW-1:0] rs_val,
  input  logic [AW-1:0] rt_val,
  input  logic [AW-1:0] br_off,
  input  logic          j_valid,
  input  logic [25:0]   j_idx,
  input  logic          jr_valid,
  input  logic          call,
  input  logic          exc_req,
  input  logic          eret_req,
  input  logic [AW-1:0] epc,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc4,
  output logic [AW-1:0] link_addr,
  output logic          taken,
  output logic [AW-1:0] ras_top,
  output logic          ras_empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    BR_NONE    = 3'b000,
    BR_BEQ     = 3'b001,
    BR_BNE     = 3'b010,
    BR_BGTZ    = 3'b011,
    BR_BLEZ    = 3'b100,
    BR_BLTZ    = 3'b101,
    BR_BGEZ    = 3'b110,
    BR_BNEZALC = 3'b111
  } br_e;

  logic [AW-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_ptr;   // next slot to write; top is ras_ptr-1
  logic [CW-1:0] ras_cnt;
  logic [PW-1:0] top_idx;

  logic          rs_zero, rs_neg, br_cond;
  logic [AW-1:0] br_target, j_target, next_pc;
  logic          ras_upd_ok, push, pop;

  assign rs_zero = (rs_val == '0);
  assign rs_neg  = rs_val[AW-1];

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    br_cond = 1'b0;
    case (br_e'(br_type))
      BR_NONE:    br_cond = 1'b0;
      BR_BEQ:     br_cond = (rs_val == rt_val);
      BR_BNE:     br_cond = (rs_val != rt_val);
      BR_BGTZ:    br_cond = !rs_neg && !rs_zero;
      BR_BLEZ:    br_cond = rs_neg || rs_zero;
      BR_BLTZ:    br_cond = rs_neg;
      BR_BGEZ:    br_cond = !rs_neg;
      BR_BNEZALC: br_cond = !rs_zero;
    endcase
  end

  assign taken     = j_valid | jr_valid | br_cond;
  assign br_target = id_pc + AW'(4) + {br_off[AW-3:0], 2'b00};
  assign j_target  = {id_pc[AW-1:28], j_idx, 2'b00};
  assign pc4       = pc + AW'(4);
  assign link_addr = id_pc + AW'(8);

  assign top_idx   = ras_ptr - 1'b1;
  assign ras_empty = (ras_cnt == '0);
  assign ras_top   = ras_empty ? '0 : ras_mem[top_idx];

  always_comb begin
    next_pc = pc4;
    if (exc_req)       next_pc = EXC_PC;
    else if (eret_req) next_pc = epc;
    else if (stall)    next_pc = pc;
    else if (jr_valid) next_pc = rs_val;
    else if (j_valid)  next_pc = j_target;
    else if (br_cond)  next_pc = br_target;
  end

  assign ras_upd_ok = !stall && !exc_req && !eret_req;
  assign push = ras_upd_ok && ((call && (j_valid || jr_valid)) ||
                               ((br_e'(br_type) == BR_BNEZALC) && taken));
  assign pop  = ras_upd_ok && jr_valid && !call && (rs_val == ras_top) && !ras_empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ras_ptr <= '0;
      ras_cnt <= '0;
      // NOTE: the stack storage is reset too, so entries read as zero after reset rather than stale data.
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else begin
      pc <= next_pc;
      if (push) begin
        // When full, the write slot holds the oldest entry and is simply overwritten.
        ras_mem[ras_ptr] <= link_addr;
        ras_ptr          <= ras_ptr + 1'b1;
        if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + 1'b1;
      end else if (pop) begin
        ras_ptr <= top_idx;
        ras_cnt <= ras_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the PC and return-address stack.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC = 32'h0000_4180;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] id_pc, rs_val, rt_val, br_off, epc;
  logic [2:0]  br_type;
  logic        j_valid, jr_valid, call, exc_req, eret_req;
  logic [25:0] j_idx;
  logic [31:0] pc, pc4, link_addr, ras_top;
  logic        taken, ras_empty;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .id_pc(id_pc), .br_type(br_type),
    .rs_val(rs_val), .rt_val(rt_val), .br_off(br_off), .j_valid(j_valid),
    .j_idx(j_idx), .jr_valid(jr_valid), .call(call), .exc_req(exc_req),
    .eret_req(eret_req), .epc(epc), .pc(pc), .pc4(pc4), .link_addr(link_addr),
    .taken(taken), .ras_top(ras_top), .ras_empty(ras_empty)
  );

  function automatic logic [31:0] m_top();
    return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
  endfunction

  function automatic logic m_cond(input logic [2:0] t, input logic [31:0] rs, input logic [31:0] rt);
    int a, b;
    a = rs;
    b = rt;
    case (t)
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return a > 0;
      3'd4: return a <= 0;
      3'd5: return a < 0;
      3'd6: return a >= 0;
      3'd7: return a != 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle();
    stall = 0; id_pc = 0; br_type = 0; rs_val = 0; rt_val = 0; br_off = 0;
    j_valid = 0; j_idx = 0; jr_valid = 0; call = 0; exc_req = 0; eret_req = 0; epc = 0;
  endtask

  task automatic model_reset();
    m_pc = RST_PC;
    m_ras.delete();
  endtask

  // Advance one clock; the model evaluates the same inputs the DUT sees at the edge.
  task automatic tick();
    logic [31:0] nxt, link;
    logic tk, push, pop, upd;
    tk = j_valid | jr_valid | m_cond(br_type, rs_val, rt_val);
    if (exc_req)       nxt = EXC_PC;
    else if (eret_req) nxt = epc;
    else if (stall)    nxt = m_pc;
    else if (jr_valid) nxt = rs_val;
    else if (j_valid)  nxt = {id_pc[31:28], j_idx, 2'b00};
    else if (tk)       nxt = id_pc + 32'd4 + (br_off << 2);
    else               nxt = m_pc + 32'd4;
    push = !stall && !exc_req && !eret_req &&
           ((call && (j_valid || jr_valid)) || (br_type == 3'd7 && tk));
    pop  = !stall && !exc_req && !eret_req && jr_valid && !call &&
           (m_ras.size() > 0) && (rs_val == m_top());
    link = id_pc + 32'd8;
    upd  = reset;
    @(posedge clk);
    #1;
    if (upd) begin
      m_pc = nxt;
      if (push) begin
        m_ras.push_back(link);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (pop) begin
        void'(m_ras.pop_back());
      end
    end
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    model_reset();
    n_vec++; if (pc !== RST_PC) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
    n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", ras_empty); end
    n_vec++; if (ras_top !== 32'h0) begin n_err++; $display("FAIL reset_top: got %h want 0", ras_top); end
    j_valid = 1; j_idx = 26'h123; call = 1;
    tick();
    n_vec++; if (pc !== RST_PC) begin n_err++; $display("FAIL reset_hold_pc: got %h want %h", pc, RST_PC); end
    n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL reset_hold_ras: got %b want 1", ras_empty); end
    idle();
    reset = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_vec++;
      if (pc !== RST_PC + 32'(4 * i)) begin n_err++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, RST_PC + 32'(4 * i)); end
      n_vec++;
      if (pc4 !== RST_PC + 32'(4 * i + 4)) begin n_err++; $display("FAIL seq_pc4_%0d: got %h want %h", i, pc4, RST_PC + 32'(4 * i + 4)); end
    end
  endtask

  task automatic test_branch();
    idle();
    br_type = 3'd1; id_pc = 32'h3004; rs_val = 5; rt_val = 5; br_off = 32'hFFFF_FFFE;
    #1;
    n_vec++; if (taken !== 1'b1) begin n_err++; $display("FAIL beq_taken: got %b want 1", taken); end
    tick();
    n_vec++; if (pc !== 32'h3000) begin n_err++; $display("FAIL beq_target: got %h want 00003000", pc); end
    rt_val = 6;
    #1;
    n_vec++; if (taken !== 1'b0) begin n_err++; $display("FAIL beq_not_taken: got %b want 0", taken); end
    tick();
    n_vec++; if (pc !== 32'h3004) begin n_err++; $display("FAIL beq_fallthru: got %h want 00003004", pc); end
    idle();
  endtask

  task automatic test_boundaries();
    logic [2:0]  t_tab  [9] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd3, 3'd7, 3'd7, 3'd2};
    logic [31:0] rs_tab [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000,
                                32'h0, 32'hFFFF_FFFF, 32'h7};
    logic        exp_tab[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    idle();
    for (int i = 0; i < 9; i++) begin
      br_type = t_tab[i]; rs_val = rs_tab[i]; rt_val = 32'h7;
      #1;
      n_vec++;
      if (taken !== exp_tab[i]) begin
        n_err++;
        $display("FAIL cond_%0d type=%0d rs=%h: got %b want %b", i, t_tab[i], rs_tab[i], taken, exp_tab[i]);
      end
    end
    idle();
  endtask

  task automatic test_ras();
    logic [31:0] exp_pop [4] = '{32'h3018, 32'h3014, 32'h3010, 32'h300C};
    idle();
    reset = 0; #1; model_reset(); #1; reset = 1;
    for (int i = 0; i < 5; i++) begin
      j_valid = 1; call = 1; id_pc = 32'h3000 + 32'(4 * i); j_idx = 26'(32'h1000 + i);
      tick();
      n_vec++; if (pc !== m_pc) begin n_err++; $display("FAIL jal_pc%0d: got %h want %h", i, pc, m_pc); end
    end
    idle();
    #1;
    n_vec++; if (ras_top !== 32'h3018) begin n_err++; $display("FAIL ras_top_full: got %h want 00003018", ras_top); end
    n_vec++; if (ras_empty !== 1'b0) begin n_err++; $display("FAIL ras_nonempty: got %b want 0", ras_empty); end
    for (int i = 0; i < 4; i++) begin
      jr_valid = 1; call = 0; rs_val = exp_pop[i]; id_pc = 32'h3100;
      #1;
      n_vec++; if (ras_top !== exp_pop[i]) begin n_err++; $display("FAIL pop_top%0d: got %h want %h", i, ras_top, exp_pop[i]); end
      tick();
      n_vec++; if (pc !== exp_pop[i]) begin n_err++; $display("FAIL jr_pc%0d: got %h want %h", i, pc, exp_pop[i]); end
    end
    n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL ras_drained: got %b want 1", ras_empty); end
    n_vec++; if (ras_top !== 32'h0) begin n_err++; $display("FAIL ras_top_empty: got %h want 0", ras_top); end
    rs_val = 32'h0;
    tick();
    n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL pop_on_empty: got %b want 1", ras_empty); end
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL jr_zero_pc: got %h want 0", pc); end
    idle();
  endtask

  task automatic test_exc();
    idle();
    j_valid = 1; call = 1; id_pc = 32'h3040; j_idx = 26'h0C10;
    tick();
    n_vec++; if (ras_top !== 32'h3048) begin n_err++; $display("FAIL exc_pre_top: got %h want 00003048", ras_top); end
    exc_req = 1; stall = 1; id_pc = 32'h3080;
    tick();
    n_vec++; if (pc !== EXC_PC) begin n_err++; $display("FAIL exc_pc: got %h want %h", pc, EXC_PC); end
    n_vec++; if (ras_top !== 32'h3048 || ras_empty !== 1'b0) begin
      n_err++; $display("FAIL exc_ras: got top=%h empty=%b want top=00003048 empty=0", ras_top, ras_empty);
    end
    idle();
    eret_req = 1; epc = 32'h3020;
    tick();
    n_vec++; if (pc !== 32'h3020) begin n_err++; $display("FAIL eret_pc: got %h want 00003020", pc); end
    n_vec++; if (ras_top !== 32'h3048) begin n_err++; $display("FAIL eret_ras: got %h want 00003048", ras_top); end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    br_type = 3'd7; rs_val = 32'h1; stall = 1; id_pc = 32'h3100; br_off = 32'h10;
    #1;
    n_vec++; if (taken !== 1'b1) begin n_err++; $display("FAIL bnezalc_taken: got %b want 1", taken); end
    tick();
    n_vec++; if (pc !== 32'h3020 || ras_top !== 32'h3048) begin
      n_err++; $display("FAIL stall_hold: got pc=%h top=%h want pc=00003020 top=00003048", pc, ras_top);
    end
    #2;
    reset = 0;
    #1;
    model_reset();
    n_vec++; if (pc !== RST_PC) begin n_err++; $display("FAIL midreset_pc: got %h want %h", pc, RST_PC); end
    n_vec++; if (ras_empty !== 1'b1 || ras_top !== 32'h0) begin
      n_err++; $display("FAIL midreset_ras: got empty=%b top=%h want empty=1 top=0", ras_empty, ras_top);
    end
    idle();
    #1;
    reset = 1;
    tick();
    n_vec++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL post_reset_push: got empty=%b want 1", ras_empty); end
    n_vec++; if (pc !== 32'h3004) begin n_err++; $display("FAIL post_reset_pc: got %h want 00003004", pc); end
  endtask

  task automatic test_random();
    logic [31:0] r;
    int kind, sel;
    for (int n = 0; n < 500; n++) begin
      idle();
      stall    = ($urandom_range(0, 3) == 0);
      exc_req  = ($urandom_range(0, 24) == 0);
      eret_req = ($urandom_range(0, 24) == 0);
      call     = $urandom_range(0, 1);
      id_pc    = {$urandom() & 32'hFFFF_FFFC};
      epc      = {$urandom() & 32'hFFFF_FFFC};
      r        = $urandom();
      br_off   = {{16{r[15]}}, r[15:0]};
      j_idx    = 26'($urandom());
      rt_val   = $urandom();
      sel      = $urandom_range(0, 5);
      case (sel)
        0, 1: rs_val = m_top();
        2:    rs_val = 32'h0;
        3:    rs_val = 32'h8000_0000;
        4:    rs_val = rt_val;
        default: rs_val = $urandom();
      endcase
      kind = $urandom_range(0, 3);
      case (kind)
        1: br_type = 3'($urandom_range(1, 7));
        2: j_valid = 1;
        3: jr_valid = 1;
        default: br_type = 3'd0;
      endcase
      #1;
      n_vec++;
      if (taken !== (j_valid | jr_valid | m_cond(br_type, rs_val, rt_val))) begin
        n_err++; $display("FAIL rnd_taken[%0d]: got %b type=%0d rs=%h rt=%h", n, taken, br_type, rs_val, rt_val);
      end
      n_vec++;
      if (pc4 !== m_pc + 32'd4 || link_addr !== id_pc + 32'd8) begin
        n_err++; $display("FAIL rnd_addr[%0d]: got pc4=%h link=%h want %h %h", n, pc4, link_addr, m_pc + 32'd4, id_pc + 32'd8);
      end
      n_vec++;
      if (ras_top !== m_top() || ras_empty !== (m_ras.size() == 0)) begin
        n_err++; $display("FAIL rnd_ras[%0d]: got top=%h empty=%b want top=%h empty=%b",
                          n, ras_top, ras_empty, m_top(), m_ras.size() == 0);
      end
      tick();
      n_vec++;
      if (pc !== m_pc) begin n_err++; $display("FAIL rnd_pc[%0d]: got %h want %h", n, pc, m_pc); end
    end
    idle();
  endtask

  initial begin
    #200_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset = 1;
    model_reset();
    test_reset();
    test_branch();
    test_boundaries();
    test_ras();
    test_exc();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
